// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: shift-register scoreboard of in-flight
// writers, load-use/RAW stall, branch flush, operand forward selects, perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              br_taken,
  output logic              stall,
  output logic              id_bubble,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd1_sel,
  output logic [SEL_W-1:0]  fwd2_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // With a bypassing register file the oldest entry is already visible to ID.
  localparam int NUM_RANGE = (RF_BYPASS != 0) ? NUM_STAGES - 1 : NUM_STAGES;

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] wb_q, wb_d;
  logic [NUM_STAGES-1:0] mr_q, mr_d;
  logic [REG_AW-1:0]     dest_q [NUM_STAGES];
  logic [REG_AW-1:0]     dest_d [NUM_STAGES];
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [NUM_STAGES-1:0] hit1, hit2;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i < NUM_RANGE) begin
        hit1[i] = id_use1 & valid_q[i] & wb_q[i] & (dest_q[i] == id_src1) & (id_src1 != '0);
        hit2[i] = id_use2 & valid_q[i] & wb_q[i] & (dest_q[i] == id_src2) & (id_src2 != '0);
      end
    end
  end

  always_comb begin
    stall    = 1'b0;
    fwd1_sel = '0;
    fwd2_sel = '0;
    if (FWD_EN != 0) begin
      stall = id_valid & (hit1[0] | hit2[0]) & mr_q[0];
      // Walk oldest to youngest so the youngest usable writer wins.
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (hit1[k] && !(k == 0 && mr_q[k])) fwd1_sel = SEL_W'(k + 1);
        if (hit2[k] && !(k == 0 && mr_q[k])) fwd2_sel = SEL_W'(k + 1);
      end
    end else begin
      stall = id_valid & (|(hit1 | hit2));
    end
  end

  assign id_bubble = stall;
  assign flush     = br_taken & id_valid & ~stall;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    valid_d    = '0;
    wb_d       = '0;
    mr_d       = '0;
    dest_d[0]  = '0;
    valid_d[0] = id_valid & ~stall;
    if (!stall) begin
      dest_d[0] = id_dest;
      wb_d[0]   = id_wb_en;
      mr_d[0]   = id_mem_r_en;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      wb_d[i]    = wb_q[i-1];
      mr_d[i]    = mr_q[i-1];
      dest_d[i]  = dest_q[i-1];
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      wb_q        <= '0;
      mr_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) dest_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      wb_q        <= wb_d;
      mr_q        <= mr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < NUM_STAGES; i++) dest_q[i] <= dest_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives three configurations of pipe_hazard_ctrl with shared ID traffic and
// checks each against an instruction-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use1, id_use2, id_wb_en, id_mem_r_en, br_taken;
  logic [4:0] id_src1, id_src2, id_dest;

  logic        stall_o [NI];
  logic        bub_o   [NI];
  logic        flush_o [NI];
  logic [2:0]  sel1_o  [NI];
  logic [2:0]  sel2_o  [NI];
  logic [15:0] scnt_o  [NI];
  logic [15:0] fcnt_o  [NI];

  logic [1:0]  s1_0, s2_0, s1_1, s2_1;
  logic [2:0]  s1_2, s2_2;
  logic [15:0] sc_0, fc_0;
  logic [3:0]  sc_1, fc_1, sc_2, fc_2;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dflt (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .stall(stall_o[0]), .id_bubble(bub_o[0]),
    .flush(flush_o[0]), .fwd1_sel(s1_0), .fwd2_sel(s2_0), .stall_cnt(sc_0), .flush_cnt(fc_0));

  pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .stall(stall_o[1]), .id_bubble(bub_o[1]),
    .flush(flush_o[1]), .fwd1_sel(s1_1), .fwd2_sel(s2_1), .stall_cnt(sc_1), .flush_cnt(fc_1));

  pipe_hazard_ctrl #(.NUM_STAGES(4), .RF_BYPASS(0), .CNT_W(4)) u_deep (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .stall(stall_o[2]), .id_bubble(bub_o[2]),
    .flush(flush_o[2]), .fwd1_sel(s1_2), .fwd2_sel(s2_2), .stall_cnt(sc_2), .flush_cnt(fc_2));

  assign sel1_o[0] = {1'b0, s1_0};
  assign sel2_o[0] = {1'b0, s2_0};
  assign sel1_o[1] = {1'b0, s1_1};
  assign sel2_o[1] = {1'b0, s2_1};
  assign sel1_o[2] = s1_2;
  assign sel2_o[2] = s2_2;
  assign scnt_o[0] = sc_0;
  assign fcnt_o[0] = fc_0;
  assign scnt_o[1] = {12'd0, sc_1};
  assign fcnt_o[1] = {12'd0, fc_1};
  assign scnt_o[2] = {12'd0, sc_2};
  assign fcnt_o[2] = {12'd0, fc_2};

  // Reference model: list of in-flight instructions, index 0 = youngest.
  typedef struct {bit v; int d; bit wb; bit mr;} ent_t;
  ent_t sb [NI][8];
  int ns_m   [NI] = '{3, 3, 4};
  bit byp_m  [NI] = '{1'b1, 1'b1, 1'b0};
  bit fwd_m  [NI] = '{1'b1, 1'b0, 1'b1};
  int cmax_m [NI] = '{65535, 15, 15};
  int m_stall [NI], m_sel1 [NI], m_sel2 [NI], m_flush [NI], m_scnt [NI], m_fcnt [NI];
  int o_stall [NI], o_bub [NI], o_flush [NI], o_sel1 [NI], o_sel2 [NI], o_scnt [NI], o_fcnt [NI];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int m = 0; m < NI; m++) begin
      for (int k = 0; k < 8; k++) sb[m][k] = '{1'b0, 0, 1'b0, 1'b0};
      m_scnt[m] = 0;
      m_fcnt[m] = 0;
    end
  endfunction

  function automatic void model_eval(int m);
    int rng, src, sel;
    bit use_s;
    rng = byp_m[m] ? ns_m[m] - 1 : ns_m[m];
    m_stall[m] = 0;
    m_sel1[m] = 0;
    m_sel2[m] = 0;
    for (int s = 1; s <= 2; s++) begin
      src   = (s == 1) ? int'(id_src1) : int'(id_src2);
      use_s = (s == 1) ? id_use1 : id_use2;
      sel   = 0;
      for (int k = 0; k < rng; k++) begin
        if (use_s && src != 0 && sb[m][k].v && sb[m][k].wb && sb[m][k].d == src) begin
          if (!fwd_m[m]) begin
            if (id_valid) m_stall[m] = 1;
          end else if (k == 0 && sb[m][0].mr) begin
            if (id_valid) m_stall[m] = 1;
          end else if (sel == 0) begin
            sel = k + 1;
          end
        end
      end
      if (s == 1) m_sel1[m] = sel;
      else        m_sel2[m] = sel;
    end
    m_flush[m] = (br_taken && id_valid && m_stall[m] == 0) ? 1 : 0;
  endfunction

  function automatic void model_clock(int m);
    for (int k = 7; k > 0; k--) sb[m][k] = sb[m][k-1];
    if (m_stall[m] != 0) sb[m][0] = '{1'b0, 0, 1'b0, 1'b0};
    else sb[m][0] = '{id_valid, int'(id_dest), id_wb_en, id_mem_r_en};
    if (m_stall[m] != 0 && m_scnt[m] < cmax_m[m]) m_scnt[m]++;
    if (m_flush[m] != 0 && m_fcnt[m] < cmax_m[m]) m_fcnt[m]++;
  endfunction

  task automatic step();
    @(negedge clk);
    if (rst) model_clear();
    for (int m = 0; m < NI; m++) begin
      model_eval(m);
      o_stall[m] = int'(stall_o[m]);
      o_bub[m]   = int'(bub_o[m]);
      o_flush[m] = int'(flush_o[m]);
      o_sel1[m]  = int'(sel1_o[m]);
      o_sel2[m]  = int'(sel2_o[m]);
      o_scnt[m]  = int'(scnt_o[m]);
      o_fcnt[m]  = int'(fcnt_o[m]);
      chk($sformatf("stall[%0d]", m), o_stall[m], m_stall[m]);
      chk($sformatf("bubble[%0d]", m), o_bub[m], m_stall[m]);
      chk($sformatf("flush[%0d]", m), o_flush[m], m_flush[m]);
      chk($sformatf("fwd1_sel[%0d]", m), o_sel1[m], m_sel1[m]);
      chk($sformatf("fwd2_sel[%0d]", m), o_sel2[m], m_sel2[m]);
      chk($sformatf("stall_cnt[%0d]", m), o_scnt[m], m_scnt[m]);
      chk($sformatf("flush_cnt[%0d]", m), o_fcnt[m], m_fcnt[m]);
    end
    @(posedge clk);
    if (!rst) for (int m = 0; m < NI; m++) model_clock(m);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_wb_en = 0; id_mem_r_en = 0; br_taken = 0;
    id_src1 = 0; id_src2 = 0; id_dest = 0;
  endtask

  task automatic instr(input int dst, input bit wb, input bit ld, input int s1, input bit u1,
                       input int s2, input bit u2, input bit br);
    id_valid = 1; id_dest = 5'(dst); id_wb_en = wb; id_mem_r_en = ld;
    id_src1 = 5'(s1); id_use1 = u1; id_src2 = 5'(s2); id_use2 = u2; br_taken = br;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    model_clear();
    do_reset();

    // Randomized traffic over a small register set so hazards are frequent.
    for (int it = 0; it < 3000; it++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_src1     = 5'($urandom_range(0, 7));
      id_src2     = 5'($urandom_range(0, 7));
      id_use1     = 1'($urandom_range(0, 1));
      id_use2     = 1'($urandom_range(0, 1));
      id_dest     = 5'($urandom_range(0, 7));
      id_wb_en    = ($urandom_range(0, 3) != 0);
      id_mem_r_en = ($urandom_range(0, 2) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      rst         = (it < 1500 && $urandom_range(0, 199) == 0);
      if (rst) br_taken = 0;
      step();
      rst = 0;
    end
    chk("sat_stall_cnt_nofwd", o_scnt[1], 15);
    chk("sat_flush_cnt_nofwd", o_fcnt[1], 15);

    // Reset mid-stream with three valid entries.
    do_reset();
    instr(1, 1, 0, 0, 0, 0, 0, 0); step();
    instr(2, 1, 1, 0, 0, 0, 0, 0); step();
    instr(3, 1, 0, 0, 0, 0, 0, 0); step();
    idle(); rst = 1; step(); rst = 0;
    chk("rst_stall", o_stall[0], 0);
    chk("rst_flush", o_flush[0], 0);
    chk("rst_scnt", o_scnt[0], 0);
    instr(6, 1, 0, 5, 1, 0, 0, 0); step();
    chk("post_rst_sel1", o_sel1[0], 0);

    // Forwarding distance: EXE, then MEM, then register file.
    do_reset();
    instr(3, 1, 0, 0, 0, 0, 0, 0);  step();
    instr(10, 1, 0, 3, 1, 0, 0, 0); step();
    chk("fwd_exe_sel1", o_sel1[0], 1);
    instr(10, 1, 0, 3, 1, 0, 0, 0); step();
    chk("fwd_mem_sel1", o_sel1[0], 2);
    instr(10, 1, 0, 3, 1, 0, 0, 0); step();
    chk("fwd_rf_sel1", o_sel1[0], 0);
    chk("fwd_no_stall", o_scnt[0], 0);

    // Load-use: one stall cycle, then forward from MEM.
    do_reset();
    instr(4, 1, 1, 0, 0, 0, 0, 0);  step();
    instr(11, 1, 0, 0, 0, 4, 1, 0); step();
    chk("lu_stall", o_stall[0], 1);
    chk("lu_bubble", o_bub[0], 1);
    step();
    chk("lu_release", o_stall[0], 0);
    chk("lu_sel2", o_sel2[0], 2);
    chk("lu_scnt", o_scnt[0], 1);

    // No forwarding: RAW on r7 stalls for two cycles.
    do_reset();
    instr(7, 1, 0, 0, 0, 0, 0, 0); step();
    instr(12, 1, 0, 7, 1, 0, 0, 0); step();
    chk("nf_stall_a", o_stall[1], 1);
    step();
    chk("nf_stall_b", o_stall[1], 1);
    step();
    chk("nf_release", o_stall[1], 0);
    chk("nf_sel1", o_sel1[1], 0);
    chk("nf_scnt", o_scnt[1], 2);

    // r0 never hits; youngest of two r9 writers wins.
    do_reset();
    instr(0, 1, 0, 0, 0, 0, 0, 0); step();
    instr(13, 1, 0, 0, 1, 0, 1, 0); step();
    chk("r0_stall", o_stall[1], 0);
    chk("r0_sel1", o_sel1[0], 0);
    instr(9, 1, 0, 0, 0, 0, 0, 0); step();
    instr(9, 1, 0, 0, 0, 0, 0, 0); step();
    instr(14, 1, 0, 9, 1, 9, 1, 0); step();
    chk("young_sel1", o_sel1[0], 1);
    chk("young_sel2", o_sel2[0], 1);

    // Branch flush, and stall beating flush.
    do_reset();
    instr(0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("br_flush", o_flush[0], 1);
    idle(); step();
    chk("br_fcnt", o_fcnt[0], 1);
    instr(4, 1, 1, 0, 0, 0, 0, 0); step();
    instr(0, 0, 0, 4, 1, 0, 0, 1); step();
    chk("br_lu_flush", o_flush[0], 0);
    chk("br_lu_stall", o_stall[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order pipeline. It keeps a shift-register scoreboard of in-flight writers downstream of ID, one entry per stage. From it the block generates load-use/RAW stalls, bubble insertion, branch flush and per-operand forwarding selects. It also keeps saturating stall/flush performance counters. It sits beside the ID stage and drives PC/IF2ID freeze, ID2EXE bubble and the EXE operand muxes.

Parameters:
REG_AW, 5, register address width
NUM_STAGES, 3, tracked entries after ID (entry 0 = EXE, 1 = MEM, 2 = WB, ...)
FWD_EN, 1, 1 = forward from tracked entries; 0 = stall on any RAW hit
RF_BYPASS, 1, 1 = register file returns the write value on same-cycle read, so the last entry never causes a hazard
CNT_W, 16, performance counter width
SEL_W, $clog2(NUM_STAGES+1), forwarding select width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_AW  ID source 1
id_src2  in  REG_AW  ID source 2
id_use1  in  1  src1 is read
id_use2  in  1  src2 is read
id_dest  in  REG_AW  ID destination
id_wb_en  in  1  ID instruction writes the register file
id_mem_r_en  in  1  ID instruction is a load
br_taken  in  1  branch resolved taken in ID
stall  out  1  freeze PC and IF2ID
id_bubble  out  1  ID2EXE captures a NOP (all enables 0)
flush  out  1  clear IF2ID
fwd1_sel  out  SEL_W  0 = register file, k = entry k-1
fwd2_sel  out  SEL_W  same, for src2
stall_cnt  out  CNT_W  cycles with stall=1, saturating
flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Scoreboard entry fields: {valid, dest, wb_en, mem_r_en}. Every clock, entry i moves to entry i+1 and the last entry is dropped.
- Entry 0 loads {id_valid & ~stall, id_dest, id_wb_en, id_mem_r_en}. When stall=1, entry 0 loads a bubble (all fields 0). The scoreboard never freezes.
- Hit(s, i): use_s & valid_i & wb_en_i & (dest_i == src_s) & (src_s != 0). Register 0 never hits.
- Effective range: entries 0..NUM_STAGES-1, or 0..NUM_STAGES-2 when RF_BYPASS=1.
- FWD_EN=1:
  - stall = id_valid & (Hit(1,0)|Hit(2,0)) & mem_r_en_0. This is load-use.
  - fwd_s_sel = k+1 for the lowest k in range with Hit(s,k) and not (k==0 & mem_r_en_0); otherwise 0. The youngest writer wins.
- FWD_EN=0: stall = id_valid & any Hit in range. fwd*_sel are forced to 0.
- id_bubble = stall.
- flush = br_taken & id_valid & ~stall. A stalled branch is not resolved, so stall beats flush on simultaneous assertion.
- stall, id_bubble, flush and fwd*_sel are combinational from inputs and registered state. Zero-cycle latency.
- Counters increment on the clock edge when their output is 1 and hold at 2^CNT_W-1.
- Reset, including mid-operation: all entries invalid, counters 0. Outputs are then stall=0, id_bubble=0, flush=0 (with br_taken=0), fwd*_sel=0, stall_cnt=0, flush_cnt=0.
- id_valid=0: no stall and no flush. The entry shifts in invalid.
- Identical srcs (src1==src2) can hit the same entry. Both sels point to it. A single stall is raised, not a double count.

Test Plan:
1. Reset asserted mid-stream with 3 valid entries -> next cycle all outputs 0, counters 0. An instruction reading r5 right after gets fwd1_sel=0.
2. FWD_EN=1: ADD r3 followed by SUB using src1=r3 -> fwd1_sel=1. One cycle later, a reader of r3 gets fwd1_sel=2. After two more instructions, fwd1_sel=0 (RF_BYPASS=1). stall stays 0.
3. LW r4 followed by ADD src2=r4 -> stall=1 and id_bubble=1 for exactly 1 cycle, stall_cnt=1. The next cycle gives fwd2_sel=2 and stall=0.
4. FWD_EN=0, RF_BYPASS=1, NUM_STAGES=3: ADD r7 followed by a use of r7 -> stall for 2 cycles, then proceed with fwd1_sel=0. stall_cnt=2.
5. Writes to r0 then a read of r0 -> no stall, fwd sel 0. Two writers to r9 (entries 0 and 1) -> sel=1 (youngest).
6. br_taken with no hazard -> flush=1, flush_cnt+1. br_taken while load-use stall -> flush=0, stall=1. A counter preloaded to 0xFFFF stays at 0xFFFF on further stalls.
